// File: rtl/cpu_clock_ctrl.sv
// CPU clock-enable generator: turns the divided tick into one-iClk enable pulses under run/halt/step control.
// Optional `CYCLE_COUNT_EN adds the oCycles enable-pulse counter port.
module cpu_clock_ctrl #(
    parameter logic [19:0] DEBOUNCE = 20'd50000
) (
    input  logic        iClk,
    input  logic        nRst,
    input  logic        iTick,
    input  logic        iRun,
    input  logic        iStep,
    input  logic        iHalt,
    output logic        oCpuEn,
    output logic        oRunning
`ifdef CYCLE_COUNT_EN
    ,
    output logic [31:0] oCycles
`endif
);

    // state    | meaning
    // ST_HALT  | idle, no enables; waits for run or a debounced step press
    // ST_RUN   | free-run, one enable per detected tick rise
    // ST_ARM   | step pressed, waiting for the next tick rise
    // ST_REL   | step issued, waiting for the button to be released
    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_ARM  = 2'd2,
        ST_REL  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  tick_s_q, tick_s_d;
    logic [1:0]  run_s_q, run_s_d;
    logic [1:0]  step_s_q, step_s_d;
    logic        step_db_q, step_db_d;
    logic [19:0] db_cnt_q, db_cnt_d;
    logic        cpu_en_q, cpu_en_d;
    logic        running_q, running_d;
    logic        rise, run_s, step_press;

    assign rise  = tick_s_q[1] & ~tick_s_q[2];
    assign run_s = run_s_q[1];

    always_comb begin
        tick_s_d  = {tick_s_q[1:0], iTick};
        run_s_d   = {run_s_q[0], iRun};
        step_s_d  = {step_s_q[0], iStep};
        step_db_d = step_db_q;
        db_cnt_d  = db_cnt_q;
        if (step_s_q[1] == step_db_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DEBOUNCE - 20'd1) begin
            step_db_d = step_s_q[1];
            db_cnt_d  = '0;
        end else begin
            db_cnt_d = db_cnt_q + 20'd1;
        end
    end

    // Press is seen on the same edge that step_db takes the new value.
    assign step_press = step_db_d & ~step_db_q;

    always_comb begin
        state_d  = state_q;
        cpu_en_d = 1'b0;
        case (state_q)
            ST_HALT: begin
                if (run_s && !iHalt)           state_d = ST_RUN;
                else if (step_press && !iHalt) state_d = ST_ARM;
            end
            ST_RUN: begin
                if (!run_s || iHalt) state_d  = ST_HALT;
                else                 cpu_en_d = rise;
            end
            ST_ARM: begin
                if (iHalt) begin
                    state_d = ST_HALT;
                end else if (rise) begin
                    cpu_en_d = 1'b1;
                    state_d  = ST_REL;
                end
            end
            ST_REL: begin
                if (!step_db_q) state_d = ST_HALT;
            end
            default: state_d = ST_HALT;
        endcase
        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            state_q   <= ST_HALT;
            tick_s_q  <= '0;
            run_s_q   <= '0;
            step_s_q  <= '0;
            step_db_q <= 1'b0;
            db_cnt_q  <= '0;
            cpu_en_q  <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_s_q  <= tick_s_d;
            run_s_q   <= run_s_d;
            step_s_q  <= step_s_d;
            step_db_q <= step_db_d;
            db_cnt_q  <= db_cnt_d;
            cpu_en_q  <= cpu_en_d;
            running_q <= running_d;
        end
    end

    assign oCpuEn   = cpu_en_q;
    assign oRunning = running_q;

`ifdef CYCLE_COUNT_EN
    logic [31:0] cycles_q, cycles_d;

    always_comb begin
        cycles_d = cycles_q + {31'd0, cpu_en_q};
    end

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) cycles_q <= '0;
        else       cycles_q <= cycles_d;
    end

    assign oCycles = cycles_q;
`endif

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Randomized bench for cpu_clock_ctrl with a tick-history reference model (DEBOUNCE=4).
// Define CYCLE_COUNT_EN to also exercise the oCycles counter and its wrap.
module tb_cpu_clock_ctrl;

    logic iClk = 1'b0;
    logic nRst = 1'b0;
    logic iTick = 1'b0;
    logic iRun = 1'b0;
    logic iStep = 1'b0;
    logic iHalt = 1'b0;
    logic oCpuEn;
    logic oRunning;
`ifdef CYCLE_COUNT_EN
    logic [31:0] oCycles;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int rst_edge = 0;
    bit samp [0:4095];
    int pulses, pulse_edge, tick_edge, run_k, run_got;
    bit chk_idle = 1'b0;

    cpu_clock_ctrl #(.DEBOUNCE(20'd4)) dut (
        .iClk     (iClk),
        .nRst     (nRst),
        .iTick    (iTick),
        .iRun     (iRun),
        .iStep    (iStep),
        .iHalt    (iHalt),
        .oCpuEn   (oCpuEn),
        .oRunning (oRunning)
`ifdef CYCLE_COUNT_EN
        ,
        .oCycles  (oCycles)
`endif
    );

    always #5 iClk = ~iClk;

    // Record the iTick value seen at every rising edge.
    always @(posedge iClk) begin
        cyc = cyc + 1;
        if (cyc < 4096) samp[cyc] = iTick;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic bit sval(int i);
        if (i <= rst_edge || i < 0 || i >= 4096) return 1'b0;
        return samp[i];
    endfunction

    // Enable after edge e follows a tick sampled high at e-2 and low at e-3.
    function automatic bit exp_en(int e);
        return sval(e - 2) & ~sval(e - 3);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at edge %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic cyc_go();
        @(posedge iClk);
        #1;
    endtask

    task automatic run_cyc(input bit t);
        iTick = t;
        cyc_go();
        chk("run_en", oCpuEn, exp_en(cyc));
        if (oCpuEn) run_got++;
        if (run_k >= 4) chk("run_running", oRunning, 1);
        run_k++;
    endtask

    task automatic run_phase(input int n);
        run_k = 0;
        run_got = 0;
        repeat (5) run_cyc(1'b0);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(3, 7)) run_cyc(1'b0);
            repeat ($urandom_range(3, 7)) run_cyc(1'b1);
        end
        repeat (5) run_cyc(1'b0);
        chk("run_pulse_cnt", run_got, n);
    endtask

    task automatic step_cyc(input bit t, input bit s);
        iTick = t;
        iStep = s;
        cyc_go();
        if (oCpuEn) begin
            pulses++;
            pulse_edge = cyc;
        end
        if (chk_idle) chk("idle_running", oRunning, 0);
    endtask

`ifdef CYCLE_COUNT_EN
    task automatic count_pulse(input string tag, input logic [31:0] exp);
        bit seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            iTick = (i < 3);
            cyc_go();
            if (oCpuEn) begin
                seen = 1'b1;
                cyc_go();
                chk(tag, oCycles, exp);
            end
        end
        chk("cnt_pulse_seen", seen, 1);
        iTick = 1'b0;
        repeat (4) cyc_go();
    endtask
`endif

    initial begin
        bit found;

        // Reset with run on and tick toggling.
        iRun = 1'b1;
        for (int i = 0; i < 10; i++) begin
            iTick = i[0];
            cyc_go();
        end
        chk("rst_en", oCpuEn, 0);
        chk("rst_running", oRunning, 0);
`ifdef CYCLE_COUNT_EN
        chk("rst_cycles", oCycles, 0);
`endif
        iTick = 1'b0;
        cyc_go();
        rst_edge = cyc;
        nRst = 1'b1;

        run_phase(5);

        // Halt raised on the edge that would consume a rise.
        iTick = 1'b1;
        cyc_go();
        cyc_go();
        iHalt = 1'b1;
        cyc_go();
        chk("halt_no_pulse", oCpuEn, 0);
        chk("halt_running", oRunning, 0);
        iRun = 1'b0;
        for (int i = 0; i < 6; i++) begin
            iTick = (i % 4) < 2;
            cyc_go();
            chk("halt_hold_en", oCpuEn, 0);
        end
        iHalt = 1'b0;
        for (int i = 0; i < 8; i++) begin
            iTick = (i % 4) < 2;
            cyc_go();
            chk("halt_off_en", oCpuEn, 0);
            chk("halt_off_running", oRunning, 0);
        end

        // Bouncing step press, then held.
        chk_idle = 1'b1;
        pulses = 0;
        pulse_edge = 0;
        tick_edge = -100;
        step_cyc(1'b0, 1'b1);
        step_cyc(1'b0, 1'b0);
        step_cyc(1'b0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            step_cyc(i >= 20 && i < 25, 1'b1);
            if (i == 20) tick_edge = cyc;
        end
        chk("step1_pulses", pulses, 1);
        chk("step1_edge", pulse_edge, tick_edge + 2);

        // Release shorter than the debounce window: no repeat.
        pulses = 0;
        step_cyc(1'b0, 1'b0);
        step_cyc(1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step_cyc(i >= 8 && i < 12, 1'b1);
        chk("step_short_rel", pulses, 0);

        // Proper release and a second press.
        pulses = 0;
        for (int i = 0; i < 8; i++) step_cyc(i >= 2 && i < 5, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step_cyc(i >= 12 && i < 16, 1'b1);
            if (i == 12) tick_edge = cyc;
        end
        chk("step2_pulses", pulses, 1);
        chk("step2_edge", pulse_edge, tick_edge + 2);
        for (int i = 0; i < 10; i++) step_cyc(1'b0, 1'b0);
        chk("step_release_quiet", pulses, 1);

        // run_s and step_press land on the same edge: run must win.
        chk_idle = 1'b0;
        pulses = 0;
        step_cyc(1'b0, 1'b1);
        step_cyc(1'b0, 1'b1);
        step_cyc(1'b0, 1'b1);
        iRun = 1'b1;
        step_cyc(1'b0, 1'b1);
        step_cyc(1'b0, 1'b1);
        step_cyc(1'b0, 1'b1);
        chk("simul_run", oRunning, 1);
        step_cyc(1'b0, 1'b0);
        step_cyc(1'b0, 1'b0);
        chk("simul_run_hold", oRunning, 1);
        for (int i = 0; i < 6; i++) step_cyc(i < 3, 1'b0);
        chk("simul_pulse", pulses, 1);

        // Reset while an enable pulse is high.
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            iTick = (i % 6) < 3;
            cyc_go();
            if (oCpuEn) found = 1'b1;
        end
        chk("rst_pulse_seen", found, 1);
        nRst = 1'b0;
        #1;
        chk("rst_async_en", oCpuEn, 0);
        chk("rst_async_run", oRunning, 0);
`ifdef CYCLE_COUNT_EN
        chk("rst_async_cycles", oCycles, 0);
`endif
        @(posedge iClk);
        #1;
        iTick = 1'b0;
        rst_edge = cyc;
        nRst = 1'b1;
        cyc_go();
        chk("post_rst_en", oCpuEn, 0);
        run_phase(3);

`ifdef CYCLE_COUNT_EN
        chk("cyc_count", oCycles, 3);
        force dut.cycles_q = 32'hFFFF_FFFE;
        cyc_go();
        release dut.cycles_q;
        chk("cyc_preload", oCycles, 32'hFFFF_FFFE);
        count_pulse("cyc_ffff", 32'hFFFF_FFFF);
        count_pulse("cyc_wrap", 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
